// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and WIDTH legality rule for the
// sequential multiply/divide unit.
package muldiv_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int WIDTH_MIN = 8;
  localparam int WIDTH_MAX = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX) && ((w % 2) == 0);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between a requester (master) and muldiv_unit (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             ready;
  logic             div_zero;

  modport master (
    output start, op, is_signed, a, b,
    input  hi, lo, busy, ready, div_zero
  );

  modport slave (
    input  start, op, is_signed, a, b,
    output hi, lo, busy, ready, div_zero
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitude extraction on entry and
// two's-complement correction of the raw unsigned result on exit.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_signed,
  output logic [WIDTH-1:0]   o_mag_a,
  output logic [WIDTH-1:0]   o_mag_b,
  output logic               o_neg_a,
  output logic               o_neg_b,
  input  logic               i_op,
  input  logic               i_neg_q,
  input  logic               i_neg_r,
  input  logic [2*WIDTH-1:0] i_res,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  assign o_neg_a = i_signed & i_a[WIDTH-1];
  assign o_neg_b = i_signed & i_b[WIDTH-1];
  assign o_mag_a = o_neg_a ? -i_a : i_a;
  assign o_mag_b = o_neg_b ? -i_b : i_b;

  // The most-negative magnitude is representable unsigned, so MIN/-1 wraps back to MIN.
  always_comb begin
    o_hi = i_res[2*WIDTH-1:WIDTH];
    o_lo = i_res[WIDTH-1:0];
    if (i_op == OP_MUL) begin
      if (i_neg_q) {o_hi, o_lo} = -i_res;
    end else begin
      if (i_neg_q) o_lo = -i_res[WIDTH-1:0];
      if (i_neg_r) o_hi = -i_res[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Sequential WIDTH x WIDTH multiply / restoring divide, one bit per cycle,
// sharing a single 2*WIDTH+1 accumulator between both operations.
//
// state | meaning
// IDLE  | waiting for start; latches operand magnitudes and signs
// RUN   | one shift-add or shift-subtract step per cycle, WIDTH cycles
// FIXUP | sign correction, result registered into hi/lo
// DONE  | ready (and div_zero) asserted for one cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic    clk,
  input logic    reset,
  muldiv_if.slave bus
);

  localparam int  CNT_W    = $clog2(WIDTH + 1);
  localparam int  AW       = 2*WIDTH + 1;
  localparam bit  WIDTH_OK = width_legal(WIDTH);

  generate
    if (!WIDTH_OK) begin : g_width_check
      $error("muldiv_unit: WIDTH must be even and within 8..64");
    end
  endgenerate

  state_t             r_state, w_next;
  logic [AW-1:0]      r_acc;
  logic [WIDTH-1:0]   r_dvs;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op, r_neg_q, r_neg_r, r_dz;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_fix_hi, w_fix_lo;
  logic               w_neg_a, w_neg_b, w_div0;
  logic [WIDTH:0]     w_mul_sum, w_div_rem, w_div_diff;
  logic               w_div_ge;
  logic [AW-1:0]      w_mul_acc, w_div_acc;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_a      (bus.a),
    .i_b      (bus.b),
    .i_signed (bus.is_signed),
    .o_mag_a  (w_mag_a),
    .o_mag_b  (w_mag_b),
    .o_neg_a  (w_neg_a),
    .o_neg_b  (w_neg_b),
    .i_op     (r_op),
    .i_neg_q  (r_neg_q),
    .i_neg_r  (r_neg_r),
    .i_res    (r_acc[2*WIDTH-1:0]),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  assign w_div0 = (bus.op == OP_DIV) && (bus.b == '0);

  // Multiply: multiplier sits in the low half and shifts out LSB first.
  assign w_mul_sum = r_acc[0] ? (r_acc[AW-1:WIDTH] + {1'b0, r_dvs}) : r_acc[AW-1:WIDTH];
  assign w_mul_acc = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: remainder in the upper half, quotient bits enter at the LSB.
  assign w_div_rem  = r_acc[AW-2:WIDTH-1];
  assign w_div_ge   = (w_div_rem >= {1'b0, r_dvs});
  assign w_div_diff = w_div_rem - {1'b0, r_dvs};
  assign w_div_acc  = {(w_div_ge ? w_div_diff : w_div_rem), r_acc[WIDTH-2:0], w_div_ge};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = w_div0 ? DONE : RUN;
      RUN:     if (r_cnt == CNT_W'(1)) w_next = FIXUP;
      FIXUP:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_op    <= bus.op;
          r_dz    <= w_div0;
          r_neg_q <= w_neg_a ^ w_neg_b;
          r_neg_r <= w_neg_a;
          r_dvs   <= w_mag_b;
          r_acc   <= {{(WIDTH+1){1'b0}}, w_mag_a};
          r_cnt   <= CNT_W'(WIDTH);
        end
        RUN: begin
          r_acc <= (r_op == OP_DIV) ? w_div_acc : w_mul_acc;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIXUP: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = (r_state != IDLE);
  assign bus.ready    = (r_state == DONE);
  assign bus.div_zero = (r_state == DONE) && r_dz;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; legal values 8..64, even.
REQ-002 SHALL have derived localparam CNT_W, default $clog2(WIDTH+1), iteration counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-006 SHALL have port op  input  1  0 = multiply, 1 = divide.
REQ-007 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 SHALL have port a  input  WIDTH  multiplicand / dividend.
REQ-009 SHALL have port b  input  WIDTH  multiplier / divisor.
REQ-010 SHALL have port hi  output  WIDTH  product upper half / remainder.
REQ-011 SHALL have port lo  output  WIDTH  product lower half / quotient.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-014 SHALL have port div_zero  output  1  one-cycle pulse, coincident with ready, on divide by zero.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FIXUP, DONE.
REQ-016 IDLE with start=1 SHALL latch op, is_signed, a and b, then go to RUN with the counter set to WIDTH.
- Exception: op=1 with b=0 goes directly to DONE.
REQ-017 Operand latch SHALL store magnitudes: absolute values when is_signed=1, and record the result sign(s).
REQ-018 RUN SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, for exactly WIDTH cycles, then go to FIXUP.
REQ-019 FIXUP SHALL apply sign correction in one cycle, then go to DONE.
- Multiply: negate the 2*WIDTH product when the operand signs differ.
- Divide: quotient truncates toward zero; remainder takes the dividend's sign.
REQ-020 DONE SHALL register the results into hi/lo, assert ready for that cycle only, and return to IDLE.
REQ-021 Latency SHALL be fixed.
- Normal operation: ready high in the cycle beginning WIDTH+2 edges after the start-sampling edge.
- Divide by zero: ready high 1 edge after the start-sampling edge.
REQ-022 Divide by zero SHALL assert div_zero together with ready and leave hi/lo unchanged.
REQ-023 Signed most-negative / -1 SHALL give lo = most-negative value and hi = 0 (wrap, no flag).
REQ-024 Unsigned mode SHALL treat all operands as magnitudes, with no sign correction.
REQ-025 start while busy=1 SHALL be ignored, with no queuing; a, b, op and is_signed changes during busy SHALL NOT affect the in-flight result.
REQ-026 start sampled in the same cycle that ready is high SHALL be ignored, because that cycle is DONE, not IDLE.
REQ-027 hi/lo SHALL hold their last value at all times except the DONE update.

Reset
REQ-028 reset=0 SHALL asynchronously force the state to IDLE and set hi=0, lo=0, busy=0, ready=0, div_zero=0, the counter to 0 and all internal registers to 0.
REQ-029 reset asserted mid-operation SHALL abort it with no ready pulse; the first start after reset deassertion SHALL be accepted normally.

Structure
REQ-030 A shared package muldiv_pkg SHALL hold:
- OP_MUL/OP_DIV encodings;
- the state enum (IDLE, RUN, FIXUP, DONE);
- the WIDTH legality check constant.
REQ-031 Sign handling SHALL live in one sub-module muldiv_sign_fix, purely combinational: magnitude extraction and final negation, parametrised by WIDTH.
REQ-032 Datapath SHALL use a single 2*WIDTH+1 accumulator/shift register shared by both operations, with no combinational WIDTH×WIDTH multiplier.

Verification (WIDTH=32 unless noted)
REQ-033 start, op=0, is_signed=1, a=0xFFFFFFF9 (-7), b=3 -> ready in cycle 34 after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_zero=0.
REQ-034 start, op=0, is_signed=0, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 start, op=1, is_signed=1, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 After a result, start op=1, b=0 -> ready=div_zero=1 one cycle later, hi/lo unchanged, busy high for exactly one cycle.
REQ-037 start multiply, pulse start again at cycle 5 with new operands, assert reset=0 at cycle 10 -> second start ignored, busy=0 and hi=lo=0 immediately, no ready pulse.
REQ-038 WIDTH=8, random signed/unsigned mul/div vs. reference model over 10k ops -> all hi/lo match, every ready at cycle 10.
